ntt_ctrl: RTL and testbench

Sequencing controller for the Kyber NTT/INTT engine. It drives the coefficient-RAM read ports, the twiddle-ROM index and the butterfly `sel` input for every butterfly in all seven layers. It also issues the write-back of each butterfly's `c`/`d` results to the same addresses after a fixed pipeline latency. It sits directly upstream of the butterfly datapath and owns the hazard-free ordering between layers.

---
 rtl/ntt_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_ntt_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_ctrl.sv
// ntt_ctrl -- sequencing controller for the Kyber NTT/INTT butterfly engine.
//
// Walks all seven butterfly layers (NTT: half-span 128..2, INTT: 2..128).
// Each layer issues 128 reads, one per cycle with no gaps. Every read is
// written back LAT cycles later to the same address pair. A DRAIN phase of
// LAT cycles between layers makes sure that no read of the next layer can
// overtake an outstanding write of the current layer.
//
// Optional feature: define NTT_CTRL_BYPASS_EN to make mode 2 (BYPASS) legal.
// BYPASS runs a single pass of 128 reads over pairs (2j, 2j+1) with twiddle
// index 0.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   start_i      one-cycle job request, sampled only in IDLE
//   mode_i       job type captured with start_i (0 NTT, 1 INTT, 2 BYPASS)
//   busy_o       high while a job is active
//   done_o       one-cycle pulse at job end
//   rd_en_o      read strobe for coefficient RAM and twiddle ROM
//   rd_addr_a_o  operand a address
//   rd_addr_b_o  operand b address
//   tw_idx_o     twiddle ROM index, aligned with rd_en_o
//   bf_sel_o     butterfly mode (captured job mode)
//   wr_en_o      write-back strobe, LAT cycles after the matching read
//   wr_addr_a_o  write address for c
//   wr_addr_b_o  write address for d
module ntt_ctrl #(
    parameter int AW  = 8,
    parameter int KW  = 7,
    parameter int LAT = 6
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [1:0]    mode_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          rd_en_o,
    output logic [AW-1:0] rd_addr_a_o,
    output logic [AW-1:0] rd_addr_b_o,
    output logic [KW-1:0] tw_idx_o,
    output logic [1:0]    bf_sel_o,
    output logic          wr_en_o,
    output logic [AW-1:0] wr_addr_a_o,
    output logic [AW-1:0] wr_addr_b_o
);

    localparam int         JW         = AW - 1;
    localparam logic [1:0] MODE_NTT   = 2'd0;
    localparam logic [1:0] MODE_INTT  = 2'd1;
    localparam logic [2:0] LAST_LAYER = 3'd6;
    localparam logic [3:0] DRAIN_LAST = 4'(LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic mode_legal(input logic [1:0] m);
`ifdef NTT_CTRL_BYPASS_EN
        return (m != 2'd3);
`else
        return (m == MODE_NTT) || (m == MODE_INTT);
`endif
    endfunction

    state_t          state_q;
    logic [1:0]      mode_q;
    logic [JW-1:0]   j_q;
    logic [2:0]      layer_q;
    logic [3:0]      drain_q;
    logic [KW-1:0]   tw_cnt_q;
    logic            busy_q;
    logic            done_q;
    logic            rd_en_q;
    logic [AW-1:0]   rd_addr_a_q;
    logic [AW-1:0]   rd_addr_b_q;
    logic [KW-1:0]   tw_idx_q;
    logic [1:0]      bf_sel_q;
    logic            dl_en_q [LAT];
    logic [AW-1:0]   dl_a_q  [LAT];
    logic [AW-1:0]   dl_b_q  [LAT];

    logic [2:0]      shift_d;
    logic [AW-1:0]   span_d;
    logic [AW-1:0]   mask_d;
    logic [AW-1:0]   j_ext_d;
    logic [AW-1:0]   addr_a_d;
    logic [AW-1:0]   addr_b_d;
    logic [KW-1:0]   tw_sel_d;
    logic [2:0]      last_layer_d;
    logic [JW-1:0]   j_next_d;
    logic            grp_wrap_d;

    // Address, twiddle and group-boundary decode for the current read slot.
    always_comb begin
        if (mode_q == MODE_INTT) begin
            shift_d = layer_q + 3'd1;
        end else begin
            shift_d = 3'd7 - layer_q;
        end
        span_d  = AW'(1) << shift_d;
        mask_d  = span_d - AW'(1);
        j_ext_d = {1'b0, j_q};
        // Insert a zero bit at position log2(len): grp*2*len + off without a multiply.
        addr_a_d     = ((j_ext_d & ~mask_d) << 1) | (j_ext_d & mask_d);
        addr_b_d     = addr_a_d | span_d;
        tw_sel_d     = tw_cnt_q;
        last_layer_d = LAST_LAYER;
`ifdef NTT_CTRL_BYPASS_EN
        if (mode_q == 2'd2) begin
            addr_a_d     = {j_q, 1'b0};
            addr_b_d     = {j_q, 1'b1};
            tw_sel_d     = KW'(0);
            last_layer_d = 3'd0;
        end else begin
            tw_sel_d     = tw_cnt_q;
        end
`endif
        j_next_d   = j_q + JW'(1);
        // The next read opens a new group when its offset bits wrap to zero.
        grp_wrap_d = ((j_next_d & mask_d[JW-1:0]) == JW'(0));
    end

    // Job FSM, read-side output registers and write-back delay line.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            mode_q      <= 2'd0;
            j_q         <= JW'(0);
            layer_q     <= 3'd0;
            drain_q     <= 4'd0;
            tw_cnt_q    <= KW'(0);
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_a_q <= AW'(0);
            rd_addr_b_q <= AW'(0);
            tw_idx_q    <= KW'(0);
            bf_sel_q    <= 2'd0;
            for (int i = 0; i < LAT; i++) begin
                dl_en_q[i] <= 1'b0;
                dl_a_q[i]  <= AW'(0);
                dl_b_q[i]  <= AW'(0);
            end
        end else begin
            busy_q      <= (state_q != S_IDLE);
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_a_q <= AW'(0);
            rd_addr_b_q <= AW'(0);
            tw_idx_q    <= KW'(0);

            dl_en_q[0] <= rd_en_q;
            dl_a_q[0]  <= rd_addr_a_q;
            dl_b_q[0]  <= rd_addr_b_q;
            for (int i = 1; i < LAT; i++) begin
                dl_en_q[i] <= dl_en_q[i-1];
                dl_a_q[i]  <= dl_a_q[i-1];
                dl_b_q[i]  <= dl_b_q[i-1];
            end

            case (state_q)
                S_IDLE: begin
                    if (start_i && mode_legal(mode_i)) begin
                        state_q  <= S_ISSUE;
                        mode_q   <= mode_i;
                        bf_sel_q <= mode_i;
                        j_q      <= JW'(0);
                        layer_q  <= 3'd0;
                        tw_cnt_q <= (mode_i == MODE_INTT) ? KW'(127) : KW'(1);
                    end
                end
                S_ISSUE: begin
                    rd_en_q     <= 1'b1;
                    rd_addr_a_q <= addr_a_d;
                    rd_addr_b_q <= addr_b_d;
                    tw_idx_q    <= tw_sel_d;
                    j_q         <= j_next_d;
                    if (grp_wrap_d) begin
                        tw_cnt_q <= (mode_q == MODE_INTT) ? (tw_cnt_q - KW'(1))
                                                          : (tw_cnt_q + KW'(1));
                    end
                    if (j_q == {JW{1'b1}}) begin
                        state_q <= S_DRAIN;
                        drain_q <= 4'd0;
                    end
                end
                S_DRAIN: begin
                    // LAT drain cycles put the next layer's first read one
                    // cycle after this layer's last write.
                    if (drain_q == DRAIN_LAST) begin
                        if (layer_q == last_layer_d) begin
                            state_q <= S_DONE;
                        end else begin
                            layer_q <= layer_q + 3'd1;
                            state_q <= S_ISSUE;
                        end
                    end else begin
                        drain_q <= drain_q + 4'd1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign rd_en_o     = rd_en_q;
    assign rd_addr_a_o = rd_addr_a_q;
    assign rd_addr_b_o = rd_addr_b_q;
    assign tw_idx_o    = tw_idx_q;
    assign bf_sel_o    = bf_sel_q;
    assign wr_en_o     = dl_en_q[LAT-1];
    assign wr_addr_a_o = dl_a_q[LAT-1];
    assign wr_addr_b_o = dl_b_q[LAT-1];

endmodule

// File: tb/tb_ntt_ctrl.sv
// Scoreboard testbench for ntt_ctrl: stimulus pushes expected reads, writes,
// done pulses and hand-computed spot vectors; a negedge monitor pops and
// compares whenever the DUT presents rd_en, wr_en or done.
module tb_ntt_ctrl;
    localparam int AW  = 8;
    localparam int KW  = 7;
    localparam int LAT = 6;
    localparam int P   = 128 + LAT;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          busy, done, rd_en, wr_en;
    logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [KW-1:0] tw_idx;
    logic [1:0]    bf_sel;

    ntt_ctrl #(.AW(AW), .KW(KW), .LAT(LAT)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode),
        .busy_o(busy), .done_o(done), .rd_en_o(rd_en),
        .rd_addr_a_o(rd_addr_a), .rd_addr_b_o(rd_addr_b), .tw_idx_o(tw_idx),
        .bf_sel_o(bf_sel), .wr_en_o(wr_en),
        .wr_addr_a_o(wr_addr_a), .wr_addr_b_o(wr_addr_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc; int a; int b; int tw; int sel; int layer;
    } exp_t;

    exp_t rd_q[$];
    exp_t wr_q[$];
    exp_t spot_q[$];
    int   done_q[$];
    int   inflight[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   ecnt     = 0;
    int   busy_from = 1;
    int   busy_to   = 0;
    bit   job_done  = 1'b0;

    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, ecnt, act, exp);
        end
    endtask

    // Monitor: compare every DUT output event against the scoreboard queues.
    always @(negedge clk) begin
        exp_t e;
        int   bad;
        chk("busy", int'(busy), int'(ecnt >= busy_from && ecnt <= busy_to));
        if (rd_en) begin
            chk("rd_expected", int'(rd_q.size() > 0), 1);
            if (rd_q.size() > 0) begin
                e = rd_q.pop_front();
                chk("rd_cycle", ecnt, e.cyc);
                chk("rd_addr_a", int'(rd_addr_a), e.a);
                chk("rd_addr_b", int'(rd_addr_b), e.b);
                chk("tw_idx", int'(tw_idx), e.tw);
                chk("bf_sel", int'(bf_sel), e.sel);
                bad = 0;
                foreach (inflight[k]) if (inflight[k] != e.layer) bad++;
                chk("layer_hazard", bad, 0);
                inflight.push_back(e.layer);
            end
        end
        if (wr_en) begin
            chk("wr_expected", int'(wr_q.size() > 0), 1);
            if (wr_q.size() > 0) begin
                e = wr_q.pop_front();
                chk("wr_cycle", ecnt, e.cyc);
                chk("wr_addr_a", int'(wr_addr_a), e.a);
                chk("wr_addr_b", int'(wr_addr_b), e.b);
            end
            if (inflight.size() > 0) void'(inflight.pop_front());
        end
        if (done) begin
            chk("done_expected", int'(done_q.size() > 0), 1);
            if (done_q.size() > 0) chk("done_cycle", ecnt, done_q.pop_front());
            job_done = 1'b1;
        end
        if (spot_q.size() > 0 && spot_q[0].cyc == ecnt) begin
            e = spot_q.pop_front();
            chk("spot_rd_en", int'(rd_en), 1);
            chk("spot_addr_a", int'(rd_addr_a), e.a);
            chk("spot_addr_b", int'(rd_addr_b), e.b);
            chk("spot_tw", int'(tw_idx), e.tw);
        end
    end

    // Reference model written from the address/twiddle formulas (division based).
    task automatic push_job(input int m, input int t0);
        int nl, len, grp, off, a, b, tw;
        nl = (m == 2) ? 1 : 7;
        for (int n = 0; n < nl; n++) begin
            for (int j = 0; j < 128; j++) begin
                if (m == 2) begin
                    a = 2 * j; b = a + 1; tw = 0;
                end else if (m == 0) begin
                    len = 128 >> n; grp = j / len; off = j % len;
                    a = grp * 2 * len + off; b = a + len; tw = (1 << n) + grp;
                end else begin
                    len = 2 << n; grp = j / len; off = j % len;
                    a = grp * 2 * len + off; b = a + len; tw = (128 >> n) - 1 - grp;
                end
                rd_q.push_back('{t0 + n * P + 1 + j, a, b, tw, m, n});
                wr_q.push_back('{t0 + n * P + 1 + j + LAT, a, b, 0, m, n});
            end
        end
        done_q.push_back(t0 + nl * P + 1);
        busy_from = t0 + 1;
        busy_to   = t0 + nl * P + 1;
    endtask

    task automatic spot(input int cyc, input int a, input int b, input int tw);
        spot_q.push_back('{cyc, a, b, tw, 0, 0});
    endtask

    task automatic begin_job(input int m, input bit run, output int t0);
        @(negedge clk);
        t0 = ecnt + 1;
        job_done = 1'b0;
        start = 1'b1;
        mode  = 2'(m);
        if (run) push_job(m, t0);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !job_done; i++) @(negedge clk);
        chk("job_done_seen", int'(job_done), 1);
    endtask

    task automatic pulse_start_at(input int cyc, input int m);
        while (ecnt < cyc - 1) @(negedge clk);
        start = 1'b1;
        mode  = 2'(m);
        @(negedge clk);
        start = 1'b0;
    endtask

    function automatic int any_out();
        return int'(|{busy, done, rd_en, rd_addr_a, rd_addr_b, tw_idx, bf_sel,
                      wr_en, wr_addr_a, wr_addr_b});
    endfunction

    initial begin
        int t0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", any_out(), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // NTT with spurious starts at cycles 50 and 500 and a mid-job mode change.
        begin_job(0, 1'b1, t0);
        mode = 2'd3;
        spot(t0 + 1, 0, 128, 1);
        spot(t0 + 135, 0, 64, 2);
        spot(t0 + 199, 128, 192, 3);
        spot(t0 + 931, 252, 254, 127);
        spot(t0 + 932, 253, 255, 127);
        pulse_start_at(t0 + 50, 1);
        pulse_start_at(t0 + 500, 0);
        wait_done(7 * P + 20);
        repeat (3) @(negedge clk);

        // INTT.
        begin_job(1, 1'b1, t0);
        spot(t0 + 1, 0, 2, 127);
        spot(t0 + 2, 1, 3, 127);
        spot(t0 + 3, 4, 6, 126);
        spot(t0 + 805, 0, 128, 1);
        spot(t0 + 932, 127, 255, 1);
        wait_done(7 * P + 20);
        repeat (3) @(negedge clk);

        // Illegal mode 3 is ignored.
        begin_job(3, 1'b0, t0);
        repeat (20) @(negedge clk);
        chk("mode3_busy", int'(busy), 0);
        chk("mode3_no_done", int'(job_done), 0);

`ifdef NTT_CTRL_BYPASS_EN
        begin_job(2, 1'b1, t0);
        spot(t0 + 1, 0, 1, 0);
        spot(t0 + 128, 254, 255, 0);
        wait_done(P + 20);
        repeat (3) @(negedge clk);
`else
        begin_job(2, 1'b0, t0);
        repeat (20) @(negedge clk);
        chk("mode2_busy", int'(busy), 0);
        chk("mode2_no_done", int'(job_done), 0);
`endif

        // Reset at cycle 300 of an NTT aborts it.
        begin_job(0, 1'b1, t0);
        while (ecnt < t0 + 299) @(negedge clk);
        #1;
        rst = 1'b1;
        rd_q.delete(); wr_q.delete(); spot_q.delete(); done_q.delete(); inflight.delete();
        busy_from = 1;
        busy_to   = 0;
        #1;
        chk("abort_reset_outputs", any_out(), 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("abort_no_done", int'(job_done), 0);

        // Fresh NTT after the abort.
        begin_job(0, 1'b1, t0);
        spot(t0 + 1, 0, 128, 1);
        spot(t0 + 931, 252, 254, 127);
        wait_done(7 * P + 20);
        repeat (5) @(negedge clk);

        chk("rd_q_drained", rd_q.size(), 0);
        chk("wr_q_drained", wr_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);
        chk("spot_q_drained", spot_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
